// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 codes, sequencer states, iteration count and result helpers.
package ex_mdu_pkg;

  // M-extension funct3 codes
  localparam logic [2:0] MduMul    = 3'd0;
  localparam logic [2:0] MduMulh   = 3'd1;
  localparam logic [2:0] MduMulhsu = 3'd2;
  localparam logic [2:0] MduMulhu  = 3'd3;
  localparam logic [2:0] MduDiv    = 3'd4;
  localparam logic [2:0] MduDivu   = 3'd5;
  localparam logic [2:0] MduRem    = 3'd6;
  localparam logic [2:0] MduRemu   = 3'd7;

  localparam int         MduIterations = 32;
  localparam logic [4:0] MduLastCnt    = 5'(MduIterations - 1);

  typedef enum logic [1:0] {
    MduIdle = 2'd0,
    MduRun  = 2'd1,
    MduDone = 2'd2
  } mdu_state_e;

  // Two's-complement negate, 32 bits
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Two's-complement negate, 64 bits
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Apply the sign fix to the raw magnitudes and pick the architectural result.
  // For multiply acc holds the 64-bit product; for divide acc holds
  // {remainder, quotient}.
  function automatic logic [31:0] mdu_result(input logic [2:0] op, input logic s1,
                                             input logic s2, input logic [63:0] acc);
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    prod = (s1 ^ s2) ? neg64(acc) : acc;
    quo  = (s1 ^ s2) ? neg32(acc[31:0]) : acc[31:0];
    rem  = s1 ? neg32(acc[63:32]) : acc[63:32];
    case (op)
      MduMul:                       return prod[31:0];
      MduMulh, MduMulhsu, MduMulhu: return prod[63:32];
      MduDiv, MduDivu:              return quo;
      default:                      return rem;
    endcase
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit: 32-step shift-add multiply and restoring
// divide over magnitudes, sign fixed when the result is registered.
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  mdu_state_e  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        s1_q, s1_d, s2_q, s2_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        stallreq_s;
  logic        s1_s, s2_s;
  logic [4:0]  div_idx_s;
  logic [32:0] rem_sh_s;
  logic        rem_ge_s;

  // Next-state, datapath step and stall request
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = 32'd0;
    ready_d    = 1'b0;
    stallreq_s = 1'b0;

    s1_s = opdata1_i[31] & ((op_i == MduMulh) | (op_i == MduMulhsu) |
                            (op_i == MduDiv)  | (op_i == MduRem));
    s2_s = opdata2_i[31] & ((op_i == MduMulh) | (op_i == MduDiv) | (op_i == MduRem));

    // Restoring divide step: the shifted partial remainder needs 33 bits
    // because the divisor magnitude can exceed 2^31 for unsigned divides.
    div_idx_s = 5'd31 - cnt_q;
    rem_sh_s  = {acc_q[63:32], a_q[div_idx_s]};
    rem_ge_s  = (rem_sh_s >= {1'b0, b_q});

    case (state_q)
      MduIdle: begin
        if (start_i && !annul_i) begin
          stallreq_s = 1'b1;
          op_d  = op_i;
          s1_d  = s1_s;
          s2_d  = s2_s;
          a_d   = s1_s ? neg32(opdata1_i) : opdata1_i;
          b_d   = s2_s ? neg32(opdata2_i) : opdata2_i;
          acc_d = 64'd0;
          cnt_d = 5'd0;
          if (op_i[2] && (opdata2_i == 32'd0)) begin
            result_d = op_i[1] ? opdata1_i : 32'hFFFF_FFFF;
            ready_d  = 1'b1;
            state_d  = MduDone;
          end else if (((op_i == MduDiv) || (op_i == MduRem)) &&
                       (opdata1_i == 32'h8000_0000) && (opdata2_i == 32'hFFFF_FFFF)) begin
            result_d = op_i[1] ? 32'd0 : 32'h8000_0000;
            ready_d  = 1'b1;
            state_d  = MduDone;
          end else begin
            state_d = MduRun;
          end
        end else begin
          stallreq_s = 1'b0;
        end
      end
      MduRun: begin
        stallreq_s = 1'b1;
        if (!op_q[2]) begin
          if (b_q[cnt_q]) begin
            acc_d = acc_q + ({32'd0, a_q} << cnt_q);
          end else begin
            acc_d = acc_q;
          end
        end else begin
          acc_d[63:32] = rem_ge_s ? 32'(rem_sh_s - {1'b0, b_q}) : rem_sh_s[31:0];
          acc_d[31:0]  = {acc_q[30:0], rem_ge_s};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MduLastCnt) begin
          result_d = mdu_result(op_q, s1_q, s2_q, acc_d);
          ready_d  = 1'b1;
          state_d  = MduDone;
        end else begin
          state_d = MduRun;
        end
      end
      MduDone: begin
        state_d = MduIdle;
      end
      default: begin
        state_d = MduIdle;
      end
    endcase

    if (annul_i) begin
      state_d    = MduIdle;
      result_d   = 32'd0;
      ready_d    = 1'b0;
      stallreq_s = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State, operand latches, accumulator and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MduIdle;
      op_q     <= 3'd0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = stallreq_s & ~rst;

endmodule
